// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] SYSCALL_WORD = 32'h0000_000C;

    // A fetch target is usable only when word aligned and inside the memory.
    function automatic logic target_ok(input logic [31:0] target, input logic [31:0] limit);
        return (target[1:0] == 2'b00) && (target < limit);
    endfunction

endpackage

// File: rtl/imem_bytes.sv
// Byte-wide instruction memory: one synchronous byte write port, one
// combinational big-endian 32-bit read port. Contents survive reset.
module imem_bytes
    import fetch_pkg::*;
#(
    parameter int IMEM_BYTES = 1024,
    parameter int AW         = $clog2(IMEM_BYTES)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_word
);

    logic [7:0] mem_r [IMEM_BYTES];

    // Byte write from the load stream; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_word = {mem_r[rd_addr],
                      mem_r[rd_addr + AW'(32'd1)],
                      mem_r[rd_addr + AW'(32'd2)],
                      mem_r[rd_addr + AW'(32'd3)]};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program loader, PC register, next-PC selection,
// and the LOAD/RUN/HALT/FAULT control FSM.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    input  logic        load_done,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        running,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    localparam int          AW         = $clog2(IMEM_BYTES);
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);
    localparam logic [AW:0] LOAD_LIMIT = (AW+1)'(IMEM_BYTES);

    fetch_state_e state_r;
    logic [AW:0]  load_addr_r;
    logic         load_ready_r;
    logic [31:0]  pc_r;
    logic [31:0]  retired_r;
    logic         running_r;
    logic         halted_r;
    logic         fault_r;

    logic         load_we_s;
    logic [AW:0]  load_addr_inc_s;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  next_pc_s;
    logic [31:0]  instr_s;

    assign load_we_s       = (state_r == ST_LOAD) && load_valid && load_ready_r;
    assign load_addr_inc_s = load_addr_r + {{AW{1'b0}}, 1'b1};
    assign pc_plus4_s      = pc_r + 32'd4;

    imem_bytes #(.IMEM_BYTES(IMEM_BYTES), .AW(AW)) u_imem (
        .clk     (clk),
        .wr_en   (load_we_s),
        .wr_addr (load_addr_r[AW-1:0]),
        .wr_data (load_byte),
        .rd_addr (pc_r[AW-1:0]),
        .rd_word (instr_s)
    );

    // Next-PC selection in priority order: stall, JR, J, branch, sequential.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (stall) begin
            next_pc_s = pc_r;
        end else if (jump_reg) begin
            next_pc_s = reg_target;
        end else if (jump) begin
            next_pc_s = {pc_plus4_s[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc_s = pc_plus4_s + {{14{branch_offset[15]}}, branch_offset, 2'b00};
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Control FSM with its registered status outputs, PC and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_LOAD;
            load_addr_r  <= {(AW+1){1'b0}};
            load_ready_r <= 1'b1;
            pc_r         <= RESET_PC;
            retired_r    <= 32'd0;
            running_r    <= 1'b0;
            halted_r     <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (load_we_s) begin
                        load_addr_r  <= load_addr_inc_s;
                        load_ready_r <= (load_addr_inc_s < LOAD_LIMIT);
                    end
                    // A byte arriving with load_done is still written above.
                    if (load_done) begin
                        state_r      <= ST_RUN;
                        running_r    <= 1'b1;
                        load_ready_r <= 1'b0;
                        pc_r         <= RESET_PC;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (instr_s == SYSCALL_WORD) begin
                            state_r   <= ST_HALT;
                            running_r <= 1'b0;
                            halted_r  <= 1'b1;
                            retired_r <= retired_r + 32'd1;
                        end else if (!target_ok(next_pc_s, IMEM_LIMIT)) begin
                            state_r   <= ST_FAULT;
                            running_r <= 1'b0;
                            fault_r   <= 1'b1;
                        end else begin
                            pc_r      <= next_pc_s;
                            retired_r <= retired_r + 32'd1;
                        end
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                end
                default: begin
                    state_r   <= ST_FAULT;
                    running_r <= 1'b0;
                    fault_r   <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = load_ready_r;
    assign instr      = instr_s;
    assign pc         = pc_r;
    assign pc_plus4   = pc_plus4_s;
    assign running    = running_r;
    assign halted     = halted_r;
    assign fault      = fault_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1024-byte instance for program flow and
// an 8-byte instance for the loader capacity boundary.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n, load_valid, load_done, stall, branch_taken, jump, jump_reg;
    logic [7:0]  load_byte;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] reg_target;
    logic        load_ready, running, halted, fault;
    logic [31:0] instr, pc, pc_plus4, retired;

    logic        reset_n_sm, load_valid_sm, load_done_sm;
    logic [7:0]  load_byte_sm;
    logic        load_ready_sm, running_sm, halted_sm, fault_sm;
    logic [31:0] instr_sm, pc_sm, pc_plus4_sm, retired_sm;

    int vectors;
    int miscompares;

    fetch_unit #(.IMEM_BYTES(1024), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_byte(load_byte),
        .load_ready(load_ready), .load_done(load_done), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_target(jump_target), .jump_reg(jump_reg), .reg_target(reg_target),
        .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .running(running),
        .halted(halted), .fault(fault), .retired(retired)
    );

    fetch_unit #(.IMEM_BYTES(8), .RESET_PC(32'h0)) dut_sm (
        .clk(clk), .reset_n(reset_n_sm), .load_valid(load_valid_sm), .load_byte(load_byte_sm),
        .load_ready(load_ready_sm), .load_done(load_done_sm), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .jump_target(jump_target), .jump_reg(jump_reg), .reg_target(reg_target),
        .instr(instr_sm), .pc(pc_sm), .pc_plus4(pc_plus4_sm), .running(running_sm),
        .halted(halted_sm), .fault(fault_sm), .retired(retired_sm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0; jump = 1'b0;
        jump_target = 26'h0; jump_reg = 1'b0; reg_target = 32'h0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        load_valid = 1'b1; load_byte = b;
        step();
        load_valid = 1'b0;
    endtask

    task automatic start_run();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL reset_running: got %b want 0", running); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault); end
        vectors++; if (retired !== 32'h0) begin miscompares++; $display("FAIL reset_retired: got %h want 0", retired); end
    endtask

    task automatic test_basic_program();
        logic [7:0] prog [8];
        prog = '{8'h34, 8'h10, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h0C};
        for (int i = 0; i < 8; i++) push_byte(prog[i]);
        start_run();
        vectors++; if (running !== 1'b1) begin miscompares++; $display("FAIL basic_running: got %b want 1", running); end
        vectors++; if (instr !== 32'h341000F0) begin miscompares++; $display("FAIL basic_instr0: got %h want 341000f0", instr); end
        vectors++; if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL basic_pc_plus4: got %h want 4", pc_plus4); end
        step();
        vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL basic_pc1: got %h want 4", pc); end
        vectors++; if (instr !== 32'h0000000C) begin miscompares++; $display("FAIL basic_instr1: got %h want 0000000c", instr); end
        step();
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL basic_halted: got %b want 1", halted); end
        vectors++; if (retired !== 32'd2) begin miscompares++; $display("FAIL basic_retired: got %0d want 2", retired); end
        vectors++; if (running !== 1'b0) begin miscompares++; $display("FAIL basic_not_running: got %b want 0", running); end
        jump = 1'b1; jump_target = 26'h0;
        step(); step();
        clear_ctrl();
        vectors++; if (pc !== 32'h4 || halted !== 1'b1 || retired !== 32'd2) begin miscompares++; $display("FAIL halt_terminal: got pc=%h halted=%b retired=%0d want pc=4 halted=1 retired=2", pc, halted, retired); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        for (int i = 0; i < 64; i++) push_byte(8'h00);
        start_run();
        for (int i = 0; i < 4; i++) step();
        vectors++; if (pc !== 32'h10 || retired !== 32'd4) begin miscompares++; $display("FAIL seq_pc: got pc=%h retired=%0d want 10/4", pc, retired); end
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step();
        vectors++; if (pc !== 32'h0C) begin miscompares++; $display("FAIL branch_back: got %h want 0c", pc); end
        clear_ctrl(); step();
        branch_taken = 1'b1; branch_offset = 16'hFFFE; jump = 1'b1; jump_target = 26'd5;
        step();
        vectors++; if (pc !== 32'h14 || retired !== 32'd7) begin miscompares++; $display("FAIL jump_wins: got pc=%h retired=%0d want 14/7", pc, retired); end
        clear_ctrl(); branch_taken = 1'b1; branch_offset = 16'h0002;
        step();
        vectors++; if (pc !== 32'h20) begin miscompares++; $display("FAIL branch_fwd: got %h want 20", pc); end
        clear_ctrl(); jump = 1'b1; jump_target = 26'd0; jump_reg = 1'b1; reg_target = 32'h3C;
        step();
        vectors++; if (pc !== 32'h3C || retired !== 32'd9) begin miscompares++; $display("FAIL jr_wins: got pc=%h retired=%0d want 3c/9", pc, retired); end
        clear_ctrl();
    endtask

    task automatic test_stall();
        jump = 1'b1; jump_target = 26'd2;
        step();
        clear_ctrl();
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL stall_setup: got %h want 8", pc); end
        stall = 1'b1; jump = 1'b1; jump_target = 26'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (pc !== 32'h8 || retired !== 32'd10) begin miscompares++; $display("FAIL stall_hold: got pc=%h retired=%0d want 8/10", pc, retired); end
        end
        clear_ctrl();
        step();
        vectors++; if (pc !== 32'h0C || retired !== 32'd11) begin miscompares++; $display("FAIL stall_release: got pc=%h retired=%0d want 0c/11", pc, retired); end
    endtask

    task automatic test_fault();
        jump_reg = 1'b1; reg_target = 32'h6;
        step();
        vectors++; if (fault !== 1'b1 || pc !== 32'h0C || retired !== 32'd11 || running !== 1'b0) begin miscompares++; $display("FAIL jr_misaligned: got fault=%b pc=%h retired=%0d running=%b want 1/0c/11/0", fault, pc, retired, running); end
        clear_ctrl(); jump = 1'b1; step(); clear_ctrl();
        vectors++; if (fault !== 1'b1 || pc !== 32'h0C) begin miscompares++; $display("FAIL fault_terminal: got fault=%b pc=%h want 1/0c", fault, pc); end
        do_reset(); start_run();
        jump_reg = 1'b1; reg_target = 32'd1024;
        step(); clear_ctrl();
        vectors++; if (fault !== 1'b1 || pc !== 32'h0 || retired !== 32'd0) begin miscompares++; $display("FAIL jr_oob: got fault=%b pc=%h retired=%0d want 1/0/0", fault, pc, retired); end
        do_reset(); start_run();
        jump_reg = 1'b1; reg_target = 32'h3FC;
        step(); clear_ctrl();
        vectors++; if (fault !== 1'b0 || pc !== 32'h3FC) begin miscompares++; $display("FAIL jr_last_word: got fault=%b pc=%h want 0/3fc", fault, pc); end
        do_reset(); start_run();
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step(); clear_ctrl();
        vectors++; if (fault !== 1'b1 || pc !== 32'h0) begin miscompares++; $display("FAIL branch_underflow: got fault=%b pc=%h want 1/0", fault, pc); end
    endtask

    task automatic test_syscall_stall();
        logic [7:0] prog [8];
        prog = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0C};
        do_reset();
        for (int i = 0; i < 8; i++) push_byte(prog[i]);
        start_run();
        step();
        stall = 1'b1;
        step(); step();
        vectors++; if (halted !== 1'b0 || pc !== 32'h4 || retired !== 32'd1) begin miscompares++; $display("FAIL syscall_stalled: got halted=%b pc=%h retired=%0d want 0/4/1", halted, pc, retired); end
        stall = 1'b0;
        step();
        vectors++; if (halted !== 1'b1 || pc !== 32'h4 || retired !== 32'd2) begin miscompares++; $display("FAIL syscall_release: got halted=%b pc=%h retired=%0d want 1/4/2", halted, pc, retired); end
    endtask

    task automatic test_reset_mid_run();
        do_reset(); start_run();
        jump = 1'b1; jump_target = 26'd8;
        step(); clear_ctrl();
        vectors++; if (pc !== 32'h20 || running !== 1'b1) begin miscompares++; $display("FAIL midrun_setup: got pc=%h running=%b want 20/1", pc, running); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (pc !== 32'h0 || load_ready !== 1'b1 || retired !== 32'd0 || running !== 1'b0) begin miscompares++; $display("FAIL async_reset: got pc=%h ready=%b retired=%0d running=%b want 0/1/0/0", pc, load_ready, retired, running); end
        reset_n = 1'b1;
        step();
        push_byte(8'h00); push_byte(8'h00); push_byte(8'h00);
        load_valid = 1'b1; load_byte = 8'h0C; load_done = 1'b1;
        step();
        load_valid = 1'b0; load_done = 1'b0;
        vectors++; if (running !== 1'b1 || instr !== 32'h0000000C || pc !== 32'h0) begin miscompares++; $display("FAIL reload_run: got running=%b instr=%h pc=%h want 1/0000000c/0", running, instr, pc); end
        step();
        vectors++; if (halted !== 1'b1 || retired !== 32'd1) begin miscompares++; $display("FAIL reload_halt: got halted=%b retired=%0d want 1/1", halted, retired); end
    endtask

    task automatic test_small_mem();
        reset_n_sm = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            load_valid_sm = 1'b1; load_byte_sm = 8'h11 + 8'(i);
            step();
            load_valid_sm = 1'b0;
            if (i < 8) begin
                vectors++; if (load_ready_sm !== (i < 7)) begin miscompares++; $display("FAIL small_ready_%0d: got %b want %b", i, load_ready_sm, (i < 7)); end
            end
        end
        load_done_sm = 1'b1; step(); load_done_sm = 1'b0;
        vectors++; if (instr_sm !== 32'h11121314 || running_sm !== 1'b1 || pc_plus4_sm !== 32'h4) begin miscompares++; $display("FAIL small_word0: got instr=%h running=%b pc4=%h want 11121314/1/4", instr_sm, running_sm, pc_plus4_sm); end
        step();
        vectors++; if (instr_sm !== 32'h15161718 || pc_sm !== 32'h4) begin miscompares++; $display("FAIL small_word1: got instr=%h pc=%h want 15161718/4", instr_sm, pc_sm); end
        step();
        vectors++; if (fault_sm !== 1'b1 || pc_sm !== 32'h4 || halted_sm !== 1'b0 || retired_sm !== 32'd1) begin miscompares++; $display("FAIL small_oob: got fault=%b pc=%h halted=%b retired=%0d want 1/4/0/1", fault_sm, pc_sm, halted_sm, retired_sm); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors = 0; miscompares = 0;
        reset_n = 1'b0; load_valid = 1'b0; load_byte = 8'h0; load_done = 1'b0;
        reset_n_sm = 1'b0; load_valid_sm = 1'b0; load_byte_sm = 8'h0; load_done_sm = 1'b0;
        clear_ctrl();
        step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_basic_program();
        test_branch_jump();
        test_stall();
        test_fault();
        test_syscall_stall();
        test_reset_mid_run();
        test_small_mem();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
